c1_input_frame_buffer: RTL

- Upstream neighbour of the C1S2 conv/pool layer.
- Accepts a raster-order 16-bit pixel stream of one IN_LEN x IN_LEN image and writes it, zero-padded by PAD on every side, into an H_IMAGE_LEN x V_IMAGE_LEN frame memory.
- Serves 5 independent read addresses per cycle (the layer's rd_addr_out_5P / rd_data_in_5P bus).
- Holds layer_en high until the layer reports completion, then returns to IDLE.

---
 rtl/c1_input_frame_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/c1_input_frame_buffer.sv
// Zero-padded frame loader with 5 replicated read ports (1-cycle registered read); stalls the pixel stream via s_ready only at interior positions.
// Optional C1_IN_STALL_CNT_EN adds stall_cnt: LOAD cycles spent waiting on s_valid at interior positions.
module c1_input_frame_buffer #(
  parameter int IN_LEN      = 31,
  parameter int PAD         = 2,
  parameter int H_IMAGE_LEN = 35,
  parameter int V_IMAGE_LEN = 35,
  parameter int DEPTH       = 1225
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  input  logic [159:0] rd_addr_in_5P,
  output logic [79:0]  rd_data_out_5P,
  output logic         layer_en,
  input  logic         layer_work_finished,
  output logic         frame_done,
`ifdef C1_IN_STALL_CNT_EN
  output logic [31:0]  stall_cnt,
`endif
  output logic         frame_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nxt;

  logic [31:0] row, col, wr_addr;
  logic [15:0] wr_data;
  logic        interior, last_pix, at_end, wr_en, accept;

  always_comb begin
    interior  = (row >= PAD) && (row < PAD + IN_LEN) &&
                (col >= PAD) && (col < PAD + IN_LEN);
    last_pix  = (row == PAD + IN_LEN - 1) && (col == PAD + IN_LEN - 1);
    at_end    = (row == V_IMAGE_LEN - 1) && (col == H_IMAGE_LEN - 1);
    s_ready   = (state == LOAD) && interior;
    accept    = s_ready && s_valid;
    // Pad positions always advance; interior positions wait for a pixel.
    wr_en     = (state == LOAD) && (!interior || s_valid);
    wr_data   = interior ? s_data : 16'h0000;
    wr_addr   = row * H_IMAGE_LEN + col;
    layer_en  = (state == RUN);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (wr_en && at_end) state_nxt = RUN;
      RUN:     if (layer_work_finished) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= (state == RUN) && layer_work_finished;
      if (state == IDLE && start) begin
        row       <= '0;
        col       <= '0;
        frame_err <= 1'b0;
      end else if (wr_en) begin
        if (col == H_IMAGE_LEN - 1) begin
          col <= '0;
          row <= row + 32'd1;
        end else begin
          col <= col + 32'd1;
        end
        if (accept && (s_last != last_pix)) frame_err <= 1'b1;
      end
    end
  end

`ifdef C1_IN_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (s_ready && !s_valid && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  // One memory copy per read port so all five reads proceed in the same cycle.
  for (genvar p = 0; p < 5; p++) begin : g_copy
    logic [15:0] mem [DEPTH];
    logic [31:0] rd_addr;
    logic [15:0] rd_q;

    assign rd_addr = rd_addr_in_5P[32*p +: 32];
    assign rd_data_out_5P[16*p +: 16] = rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_addr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst)                  rd_q <= '0;
      else if (rd_addr < DEPTH) rd_q <= mem[rd_addr[AW-1:0]];
      else                      rd_q <= '0;
    end
  end

endmodule
